// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, starvation defaults and FSM encoding for the memory port arbiter.
package mem_arb_pkg;

  localparam int AW_DEF           = 5;
  localparam int DW_DEF           = 20;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int CNT_W            = 4;

  typedef enum logic [0:0] {
    PRIO_P  = 1'b0,
    FORCE_L = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Counts consecutive cycles the loader is denied; flags the denial that reaches the limit.
module arb_starve_counter
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             gnt,
  input  logic [CNT_W-1:0] limit,
  output logic             hit
);

  logic [CNT_W-1:0] cnt_r;
  logic             denied_s;

  assign denied_s = req & ~gnt;
  assign hit      = denied_s & (cnt_r == (limit - 4'd1));

  // Denial run length; saturates so a stuck requester cannot wrap it back to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= 4'd0;
    end else if (denied_s) begin
      if (cnt_r != 4'hF) begin
        cnt_r <= cnt_r + 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end else begin
      cnt_r <= 4'd0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-ported memory: pipeline has priority, loader gets a forced slot after starving.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p_req,
  input  logic          p_we,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_wdata,
  output logic          p_gnt,
  output logic          p_stall,
  output logic          p_done,
  output logic [DW-1:0] p_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_done,
  output logic [DW-1:0] l_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_wr_en,
  input  logic [DW-1:0] mem_q
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_e state_r;
  arb_state_e state_s;
  logic       starve_hit_s;

  arb_starve_counter u_starve (
    .clk   (clk),
    .reset (reset),
    .req   (l_req),
    .gnt   (l_gnt),
    .limit (LIMIT),
    .hit   (starve_hit_s)
  );

  // Grants are held off during reset so no write can reach the memory.
  always_comb begin
    p_gnt = 1'b0;
    l_gnt = 1'b0;
    if (reset) begin
      p_gnt = 1'b0;
      l_gnt = 1'b0;
    end else if (state_r == FORCE_L) begin
      l_gnt = l_req;
      p_gnt = p_req & ~l_req;
    end else begin
      p_gnt = p_req;
      l_gnt = l_req & ~p_req;
    end
  end

  assign p_stall = p_req & ~p_gnt;

  // Memory port mux: idle port presents address 0 with writes disabled.
  always_comb begin
    mem_addr  = {AW{1'b0}};
    mem_data  = {DW{1'b0}};
    mem_wr_en = 1'b0;
    if (p_gnt) begin
      mem_addr  = p_addr;
      mem_data  = p_wdata;
      mem_wr_en = p_we;
    end else if (l_gnt) begin
      mem_addr  = l_addr;
      mem_data  = l_wdata;
      mem_wr_en = l_we;
    end else begin
      mem_wr_en = 1'b0;
    end
  end

  // Next state: the forced loader slot lasts exactly one cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      PRIO_P:  state_s = starve_hit_s ? FORCE_L : PRIO_P;
      FORCE_L: state_s = PRIO_P;
      default: state_s = PRIO_P;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= PRIO_P;
    end else begin
      state_r <= state_s;
    end
  end

  // Completion pulses and read capture; writes leave the read data untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_done  <= 1'b0;
      l_done  <= 1'b0;
      p_rdata <= {DW{1'b0}};
      l_rdata <= {DW{1'b0}};
    end else begin
      p_done <= p_gnt;
      l_done <= l_gnt;
      if (p_gnt && !p_we) begin
        p_rdata <= mem_q;
      end else begin
        p_rdata <= p_rdata;
      end
      if (l_gnt && !l_we) begin
        l_rdata <= mem_q;
      end else begin
        l_rdata <= l_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 32-word memory written on the falling edge.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        p_req, p_we, p_gnt, p_stall, p_done;
  logic [4:0]  p_addr;
  logic [19:0] p_wdata, p_rdata;
  logic        l_req, l_we, l_gnt, l_done;
  logic [4:0]  l_addr;
  logic [19:0] l_wdata, l_rdata;
  logic [4:0]  mem_addr;
  logic [19:0] mem_data, mem_q;
  logic        mem_wr_en;
  logic        init_mem;
  logic [19:0] mem [0:31];

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.AW(5), .DW(20), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_gnt(p_gnt), .p_stall(p_stall), .p_done(p_done), .p_rdata(p_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_done(l_done), .l_rdata(l_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr_en(mem_wr_en), .mem_q(mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 32; i++) mem[i] <= 20'h0;
      mem[29] <= 20'h00003;
      mem[30] <= 20'h55555;
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_data;
    end
  end

  assign mem_q = mem[mem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; init_mem = 1'b1;
    p_req = 1'b1; p_we = 1'b1; p_addr = 5'd3; p_wdata = 20'hFFFFF;
    l_req = 1'b0; l_we = 1'b0; l_addr = 5'd0; l_wdata = 20'h0;
    #1;
    chk("rst_p_gnt", {31'd0, p_gnt}, 32'd0);
    chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    tick();
    tick();
    chk("rst_p_done", {31'd0, p_done}, 32'd0);
    chk("rst_p_rdata", {12'd0, p_rdata}, 32'd0);
    chk("rst_state", {31'd0, dut.state_r}, 32'd0);
    chk("rst_cnt", {28'd0, dut.u_starve.cnt_r}, 32'd0);
    reset = 1'b0; init_mem = 1'b0; p_req = 1'b0; p_we = 1'b0;

    // Single loader read of word 29
    l_req = 1'b1; l_we = 1'b0; l_addr = 5'd29;
    #1;
    chk("rd_l_gnt", {31'd0, l_gnt}, 32'd1);
    chk("rd_p_gnt", {31'd0, p_gnt}, 32'd0);
    chk("rd_mem_addr", {27'd0, mem_addr}, 32'd29);
    tick();
    chk("rd_l_done", {31'd0, l_done}, 32'd1);
    chk("rd_l_rdata", {12'd0, l_rdata}, 32'd3);
    l_req = 1'b0;
    tick();
    chk("rd_l_done_end", {31'd0, l_done}, 32'd0);
    chk("rd_l_rdata_hold", {12'd0, l_rdata}, 32'd3);

    // Pipeline write then back-to-back read of address 7
    p_req = 1'b1; p_we = 1'b1; p_addr = 5'd7; p_wdata = 20'h0ABCD;
    #1;
    chk("wr_wr_en", {31'd0, mem_wr_en}, 32'd1);
    chk("wr_mem_addr", {27'd0, mem_addr}, 32'd7);
    chk("wr_mem_data", {12'd0, mem_data}, 32'h0ABCD);
    tick();
    chk("wr_p_done", {31'd0, p_done}, 32'd1);
    chk("wr_p_rdata_kept", {12'd0, p_rdata}, 32'd0);
    p_we = 1'b0;
    #1;
    chk("rd7_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("rd7_p_gnt", {31'd0, p_gnt}, 32'd1);
    tick();
    chk("rd7_p_done", {31'd0, p_done}, 32'd1);
    chk("rd7_p_rdata", {12'd0, p_rdata}, 32'h0ABCD);
    p_req = 1'b0;
    tick();
    chk("rd7_p_done_end", {31'd0, p_done}, 32'd0);

    // Loader reads back the pipeline's write
    l_req = 1'b1; l_we = 1'b0; l_addr = 5'd7;
    tick();
    chk("lrd7_l_rdata", {12'd0, l_rdata}, 32'h0ABCD);
    l_req = 1'b0;
    tick();

    // Contention: P,P,P,P,L repeating; stall only on L cycles
    p_req = 1'b1; p_we = 1'b0; p_addr = 5'd1;
    l_req = 1'b1; l_we = 1'b0; l_addr = 5'd2;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("cont_%0d", i), {29'd0, p_gnt, l_gnt, p_stall},
          (i % 5 == 4) ? 32'd3 : 32'd4);
      tick();
    end

    // Loader abandons its forced slot
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("pre_force_%0d", i), {30'd0, p_gnt, l_gnt}, 32'd2);
      tick();
    end
    chk("force_state", {31'd0, dut.state_r}, 32'd1);
    l_req = 1'b0;
    #1;
    chk("force_drop_gnt", {30'd0, p_gnt, l_gnt}, 32'd2);
    tick();
    chk("force_exit_state", {31'd0, dut.state_r}, 32'd0);
    chk("force_exit_cnt", {28'd0, dut.u_starve.cnt_r}, 32'd0);
    p_req = 1'b0;
    tick();

    // Reset during a granted loader write to address 30
    l_req = 1'b1; l_we = 1'b1; l_addr = 5'd30; l_wdata = 20'h12345;
    #1;
    chk("pre_rst_l_gnt", {31'd0, l_gnt}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_l_gnt", {31'd0, l_gnt}, 32'd0);
    chk("mid_rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    tick();
    reset = 1'b0; l_req = 1'b0; l_we = 1'b0;
    #1;
    chk("post_rst_l_done", {31'd0, l_done}, 32'd0);
    chk("post_rst_outs", {29'd0, p_done, mem_wr_en, p_gnt}, 32'd0);
    chk("post_rst_rdata", {12'd0, l_rdata | p_rdata}, 32'd0);
    chk("post_rst_mem_addr", {27'd0, mem_addr}, 32'd0);
    chk("post_rst_mem30", {12'd0, mem[30]}, 32'h55555);

    // Idle
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("idle_%0d", i),
          {22'd0, dut.u_starve.cnt_r, mem_addr, mem_wr_en}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
